// File: rtl/alu_exec_if.sv
// Request/response bundle for alu_exec: operation request in, registered result out.
// Both directions are valid/ready; the requester owns the master modport.
interface alu_exec_if #(
  parameter int XLEN = 32
) ();
  logic            in_valid;
  logic            in_ready;
  logic [6:0]      funct7;
  logic [2:0]      funct3;
  logic [1:0]      ALUOp;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            illegal;

  modport master (
    output in_valid, funct7, funct3, ALUOp, src1, src2, out_ready,
    input  in_ready, out_valid, result, illegal
  );

  modport slave (
    input  in_valid, funct7, funct3, ALUOp, src1, src2, out_ready,
    output in_ready, out_valid, result, illegal
  );
endinterface

// File: rtl/alu_exec.sv
// RV-style integer execute unit: 1-cycle ALU ops, XLEN+1-cycle iterative MUL/DIV families.
// Result is held in DONE until out_ready; in_ready drops while iterating and while a result stalls.
module alu_exec #(
  parameter int XLEN = 32
) (
  input logic       clk,
  input logic       rst,
  alu_exec_if.slave bus
);
  localparam int              SHW      = $clog2(XLEN);
  localparam logic [SHW:0]    CNT_LAST = (SHW+1)'(XLEN - 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  typedef enum logic [1:0] {K_ALU, K_ILL, K_MUL, K_DIV} kind_t;

  state_t            state;
  logic [SHW:0]      cnt;
  logic [1:0]        op_sel;
  logic              neg_q;
  logic              neg_r;
  logic [XLEN-1:0]   mcand;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   dvsr;
  logic [XLEN-1:0]   result_r;
  logic              illegal_r;
  logic              out_valid_r;

  logic              accept;
  kind_t             kind;
  logic [XLEN-1:0]   a;
  logic [XLEN-1:0]   b;
  logic [XLEN-1:0]   alu_res;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic [SHW-1:0]    shamt;
  logic              a_sgn;
  logic              b_sgn;
  logic              a_neg;
  logic              b_neg;

  logic [XLEN:0]     madd;
  logic [2*XLEN-1:0] prod_nxt;
  logic [2*XLEN-1:0] mul_full;
  logic [XLEN-1:0]   mul_res;
  logic [XLEN:0]     r_sh;
  logic              ge;
  logic [XLEN-1:0]   rem_nxt;
  logic [XLEN-1:0]   quo_nxt;
  logic [XLEN-1:0]   div_res;

  assign bus.in_ready  = ((state == IDLE) || (state == DONE && bus.out_ready)) && !rst;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.result    = result_r;
  assign bus.illegal   = illegal_r;
  assign bus.out_valid = out_valid_r;

  // Decode straight from the request; anything needing no iteration resolves to K_ALU here.
  always_comb begin
    a       = bus.src1;
    b       = bus.src2;
    shamt   = b[SHW-1:0];
    kind    = K_ILL;
    alu_res = '0;
    a_sgn   = 1'b0;
    b_sgn   = 1'b0;
    case (bus.ALUOp)
      2'b01: begin
        kind    = K_ALU;
        alu_res = a + b;
      end
      2'b10: begin
        kind    = K_ALU;
        alu_res = a ^ b;
      end
      2'b00: begin
        case (bus.funct7)
          7'b0000000: begin
            kind = K_ALU;
            case (bus.funct3)
              3'b000:  alu_res = a + b;
              3'b001:  alu_res = a << shamt;
              3'b010:  alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
              3'b011:  alu_res = {{(XLEN-1){1'b0}}, a < b};
              3'b100:  alu_res = a ^ b;
              3'b101:  alu_res = a >> shamt;
              3'b110:  alu_res = a | b;
              default: alu_res = a & b;
            endcase
          end
          7'b0100000: begin
            if (bus.funct3 == 3'b000) begin
              kind    = K_ALU;
              alu_res = a - b;
            end else if (bus.funct3 == 3'b101) begin
              kind    = K_ALU;
              alu_res = $unsigned($signed(a) >>> shamt);
            end
          end
          7'b0000001: begin
            if (bus.funct3[2]) begin
              kind  = K_DIV;
              a_sgn = !bus.funct3[0];
              b_sgn = !bus.funct3[0];
              // Divide-by-zero and signed overflow have closed-form answers; no iteration.
              if (b == '0) begin
                kind    = K_ALU;
                alu_res = bus.funct3[1] ? a : '1;
              end else if (a_sgn && a == MOST_NEG && b == '1) begin
                kind    = K_ALU;
                alu_res = bus.funct3[1] ? '0 : a;
              end
            end else begin
              kind  = K_MUL;
              a_sgn = (bus.funct3[1:0] == 2'b01) || (bus.funct3[1:0] == 2'b10);
              b_sgn = (bus.funct3[1:0] == 2'b01);
            end
          end
          default: kind = K_ILL;
        endcase
      end
      default: kind = K_ILL;
    endcase
    a_neg = a_sgn & a[XLEN-1];
    b_neg = b_sgn & b[XLEN-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

  // One shift-add / restore step per cycle; the last step feeds sign correction directly.
  always_comb begin
    madd     = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mcand} : '0);
    prod_nxt = {madd, prod[XLEN-1:1]};
    mul_full = neg_q ? -prod_nxt : prod_nxt;
    mul_res  = (op_sel == 2'b00) ? mul_full[XLEN-1:0] : mul_full[2*XLEN-1:XLEN];
    r_sh     = {rem, quo[XLEN-1]};
    ge       = r_sh >= {1'b0, dvsr};
    rem_nxt  = ge ? XLEN'(r_sh - {1'b0, dvsr}) : r_sh[XLEN-1:0];
    quo_nxt  = {quo[XLEN-2:0], ge};
    if (op_sel[1]) begin
      div_res = neg_r ? -rem_nxt : rem_nxt;
    end else begin
      div_res = neg_q ? -quo_nxt : quo_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      result_r    <= '0;
      illegal_r   <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        MUL: begin
          prod <= prod_nxt;
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            cnt         <= '0;
            result_r    <= mul_res;
            illegal_r   <= 1'b0;
            out_valid_r <= 1'b1;
            state       <= DONE;
          end
        end
        DIV: begin
          quo <= quo_nxt;
          rem <= rem_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            cnt         <= '0;
            result_r    <= div_res;
            illegal_r   <= 1'b0;
            out_valid_r <= 1'b1;
            state       <= DONE;
          end
        end
        default: begin
          if (accept) begin
            op_sel <= bus.funct3[1:0];
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            cnt    <= '0;
            case (kind)
              K_ALU: begin
                result_r    <= alu_res;
                illegal_r   <= 1'b0;
                out_valid_r <= 1'b1;
                state       <= DONE;
              end
              K_MUL: begin
                mcand       <= a_mag;
                prod        <= {{XLEN{1'b0}}, b_mag};
                out_valid_r <= 1'b0;
                state       <= MUL;
              end
              K_DIV: begin
                quo         <= a_mag;
                rem         <= '0;
                dvsr        <= b_mag;
                out_valid_r <= 1'b0;
                state       <= DIV;
              end
              default: begin
                result_r    <= '0;
                illegal_r   <= 1'b1;
                out_valid_r <= 1'b1;
                state       <= DONE;
              end
            endcase
          end else if (state == DONE && bus.out_ready) begin
            out_valid_r <= 1'b0;
            state       <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_exec.sv
// Bench for alu_exec (XLEN=32): directed vector table, stall/back-to-back and reset sequences,
// then random requests scored against an arithmetic reference model.
module tb_alu_exec;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_exec_if #(.XLEN(XLEN)) bus ();
  alu_exec #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string       name;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ill;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string name, input logic [6:0] f7, input logic [2:0] f3,
                              input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] res, input logic ill, input int lat);
    vec_t v;
    v.name = name; v.f7 = f7; v.f3 = f3; v.op = op; v.a = a; v.b = b;
    v.res = res; v.ill = ill; v.lat = lat;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic over the instruction semantics.
  task automatic model(input logic [6:0] f7, input logic [2:0] f3, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic ill, output int lat);
    longint sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    r = '0; ill = 1'b0; lat = 1;
    if (op == 2'b01) r = a + b;
    else if (op == 2'b10) r = a ^ b;
    else if (op == 2'b11) ill = 1'b1;
    else if (f7 == 7'h00) begin
      case (f3)
        3'd0: r = a + b;
        3'd1: r = a << b[4:0];
        3'd2: r = {31'b0, sa < sb};
        3'd3: r = {31'b0, a < b};
        3'd4: r = a ^ b;
        3'd5: r = a >> b[4:0];
        3'd6: r = a | b;
        default: r = a & b;
      endcase
    end else if (f7 == 7'h20) begin
      if (f3 == 3'd0) r = a - b;
      else if (f3 == 3'd5) begin sp = sa >>> b[4:0]; r = sp[31:0]; end
      else ill = 1'b1;
    end else if (f7 == 7'h01) begin
      if (!f3[2]) begin
        lat = 33;
        case (f3[1:0])
          2'd0: begin sp = sa * sb; r = sp[31:0]; end
          2'd1: begin sp = sa * sb; r = sp[63:32]; end
          2'd2: begin sp = sa * longint'(ub); r = sp[63:32]; end
          default: begin up = ua * ub; r = up[63:32]; end
        endcase
      end else if (b == 32'd0) begin
        r = f3[1] ? a : 32'hFFFF_FFFF;
      end else if (!f3[0]) begin
        sq = sa / sb; sr = sa % sb;
        r = f3[1] ? sr[31:0] : sq[31:0];
        lat = (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 1 : 33;
      end else begin
        up = f3[1] ? (ua % ub) : (ua / ub);
        r = up[31:0];
        lat = 33;
      end
    end else ill = 1'b1;
  endtask

  // Issue one request from a negedge, scramble inputs after acceptance, time the response, consume it.
  task automatic run_op(input string name, input logic [6:0] f7, input logic [2:0] f3,
                        input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic ill, output int lat, output logic busy);
    bus.funct7 = f7; bus.funct3 = f3; bus.ALUOp = op; bus.src1 = a; bus.src2 = b;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    #1;
    check({name, "/in_ready"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.funct7 = 7'($urandom); bus.funct3 = 3'($urandom); bus.ALUOp = 2'($urandom);
    bus.src1 = $urandom; bus.src2 = $urandom;
    lat = 0; busy = 1'b0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) break;
      if (bus.in_ready) busy = 1'b1;
    end
    res = bus.result;
    ill = bus.illegal;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] r, er, a, b;
    logic il, ei, bz, seen;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [1:0] op;
    int lt, el, k;

    vecs.push_back(mk("add_wrap",  7'h00, 3'd0, 2'b00, 32'd5,         32'hFFFF_FFFF, 32'h0000_0004, 1'b0, 1));
    vecs.push_back(mk("sra_shamt", 7'h20, 3'd5, 2'b00, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0, 1));
    vecs.push_back(mk("mulh_neg",  7'h01, 3'd1, 2'b00, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 1'b0, 33));
    vecs.push_back(mk("div_by0",   7'h01, 3'd4, 2'b00, 32'd7,         32'd0,         32'hFFFF_FFFF, 1'b0, 1));
    vecs.push_back(mk("rem_by0",   7'h01, 3'd6, 2'b00, 32'd7,         32'd0,         32'h0000_0007, 1'b0, 1));
    vecs.push_back(mk("div_ovf",   7'h01, 3'd4, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1));
    vecs.push_back(mk("rem_ovf",   7'h01, 3'd6, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1));
    vecs.push_back(mk("aluop11",   7'h00, 3'd0, 2'b11, 32'd1,         32'd2,         32'h0,         1'b1, 1));
    vecs.push_back(mk("sub",       7'h20, 3'd0, 2'b00, 32'd3,         32'd5,         32'hFFFF_FFFE, 1'b0, 1));
    vecs.push_back(mk("slt",       7'h00, 3'd2, 2'b00, 32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0, 1));
    vecs.push_back(mk("sltu",      7'h00, 3'd3, 2'b00, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0, 1));
    vecs.push_back(mk("sll",       7'h00, 3'd1, 2'b00, 32'd1,         32'h21,        32'd2,         1'b0, 1));
    vecs.push_back(mk("srl",       7'h00, 3'd5, 2'b00, 32'h8000_0000, 32'd4,         32'h0800_0000, 1'b0, 1));
    vecs.push_back(mk("xor",       7'h00, 3'd4, 2'b00, 32'hF0F0,      32'hFF00,      32'h0FF0,      1'b0, 1));
    vecs.push_back(mk("or",        7'h00, 3'd6, 2'b00, 32'hF0F0,      32'hFF00,      32'hFFF0,      1'b0, 1));
    vecs.push_back(mk("and",       7'h00, 3'd7, 2'b00, 32'hF0F0,      32'hFF00,      32'hF000,      1'b0, 1));
    vecs.push_back(mk("ill_f3",    7'h20, 3'd1, 2'b00, 32'd1,         32'd1,         32'h0,         1'b1, 1));
    vecs.push_back(mk("ill_f7",    7'h02, 3'd0, 2'b00, 32'd1,         32'd1,         32'h0,         1'b1, 1));
    vecs.push_back(mk("force_add", 7'h20, 3'd5, 2'b01, 32'd2,         32'd3,         32'd5,         1'b0, 1));
    vecs.push_back(mk("force_xor", 7'h01, 3'd0, 2'b10, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1));
    vecs.push_back(mk("mul_lo",    7'h01, 3'd0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         1'b0, 33));
    vecs.push_back(mk("mulhu",     7'h01, 3'd3, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33));
    vecs.push_back(mk("mulhsu",    7'h01, 3'd2, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33));
    vecs.push_back(mk("mulh_min",  7'h01, 3'd1, 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 33));
    vecs.push_back(mk("div",       7'h01, 3'd4, 2'b00, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, 33));
    vecs.push_back(mk("rem",       7'h01, 3'd6, 2'b00, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0, 33));
    vecs.push_back(mk("divu",      7'h01, 3'd5, 2'b00, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, 1'b0, 33));
    vecs.push_back(mk("remu",      7'h01, 3'd7, 2'b00, 32'hFFFF_FFF9, 32'd2,         32'd1,         1'b0, 33));
    vecs.push_back(mk("divu_by0",  7'h01, 3'd5, 2'b00, 32'd9,         32'd0,         32'hFFFF_FFFF, 1'b0, 1));
    vecs.push_back(mk("remu_by0",  7'h01, 3'd7, 2'b00, 32'd9,         32'd0,         32'd9,         1'b0, 1));

    bus.funct7 = '0; bus.funct3 = '0; bus.ALUOp = '0; bus.src1 = '0; bus.src2 = '0;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst/out_valid", 64'(bus.out_valid), 64'd0);
    check("rst/result", 64'(bus.result), 64'd0);
    check("rst/illegal", 64'(bus.illegal), 64'd0);
    check("rst/in_ready", 64'(bus.in_ready), 64'd0);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1 check("rst/in_ready_release", 64'(bus.in_ready), 64'd1);
    @(negedge clk);

    foreach (vecs[i]) begin
      run_op(vecs[i].name, vecs[i].f7, vecs[i].f3, vecs[i].op, vecs[i].a, vecs[i].b, r, il, lt, bz);
      check({vecs[i].name, "/result"}, 64'(r), 64'(vecs[i].res));
      check({vecs[i].name, "/illegal"}, 64'(il), 64'(vecs[i].ill));
      check({vecs[i].name, "/latency"}, 64'(lt), 64'(vecs[i].lat));
      if (vecs[i].lat > 1) check({vecs[i].name, "/busy_ready"}, 64'(bz), 64'd0);
    end

    // Stalled illegal response, then a new request accepted on the release cycle.
    bus.ALUOp = 2'b11; bus.funct7 = '0; bus.funct3 = '0; bus.src1 = 32'h1234; bus.src2 = 32'h5678;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    check("hold/out_valid", 64'(bus.out_valid), 64'd1);
    check("hold/illegal", 64'(bus.illegal), 64'd1);
    check("hold/result", 64'(bus.result), 64'd0);
    bus.ALUOp = 2'b00; bus.src1 = 32'd10; bus.src2 = 32'd20; bus.in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1 check("hold/in_ready_stalled", 64'(bus.in_ready), 64'd0);
      @(negedge clk);
      check("hold/out_valid_stable", 64'(bus.out_valid), 64'd1);
      check("hold/illegal_stable", 64'(bus.illegal), 64'd1);
      check("hold/result_stable", 64'(bus.result), 64'd0);
    end
    bus.out_ready = 1'b1;
    #1 check("b2b/in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1 begin bus.in_valid = 1'b0; bus.out_ready = 1'b0; end
    @(negedge clk);
    check("b2b/out_valid", 64'(bus.out_valid), 64'd1);
    check("b2b/result", 64'(bus.result), 64'd30);
    check("b2b/illegal", 64'(bus.illegal), 64'd0);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    check("b2b/out_valid_drop", 64'(bus.out_valid), 64'd0);

    // Reset in the middle of a multiply aborts it and clears the held result.
    run_op("pre_rst_add", 7'h00, 3'd0, 2'b00, 32'd1, 32'd2, r, il, lt, bz);
    check("pre_rst_add/result", 64'(r), 64'd3);
    bus.funct7 = 7'h01; bus.funct3 = 3'd1; bus.ALUOp = 2'b00;
    bus.src1 = 32'hFFFF_FFFE; bus.src2 = 32'd3;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 check("midrst/in_ready_in_rst", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    check("midrst/out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst/result", 64'(bus.result), 64'd0);
    rst = 1'b0;
    #1 check("midrst/in_ready_after", 64'(bus.in_ready), 64'd1);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    check("midrst/no_out_valid", 64'(seen), 64'd0);
    bus.out_ready = 1'b0;

    for (int i = 0; i < 300; i++) begin
      k  = $urandom_range(0, 9);
      op = (k == 0) ? 2'b01 : (k == 1) ? 2'b10 : (k == 2) ? 2'b11 : 2'b00;
      k  = $urandom_range(0, 9);
      f7 = (k < 3) ? 7'h00 : (k < 5) ? 7'h20 : (k < 9) ? 7'h01 : 7'($urandom);
      f3 = 3'($urandom);
      a  = pick();
      b  = pick();
      model(f7, f3, op, a, b, er, ei, el);
      run_op($sformatf("rnd%0d", i), f7, f3, op, a, b, r, il, lt, bz);
      check($sformatf("rnd%0d/result f7=%h f3=%0d op=%0d a=%h b=%h", i, f7, f3, op, a, b), 64'(r), 64'(er));
      check($sformatf("rnd%0d/illegal", i), 64'(il), 64'(ei));
      check($sformatf("rnd%0d/latency", i), 64'(lt), 64'(el));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
